data_mem_ctrl: RTL and testbench
================================

Name: data_mem_ctrl

Overview:
Data-memory controller directly downstream of the multicycle CPU's data port. It consumes MemRead, MemWrite, address_data and data_in, and produces data_out.
- Services word accesses to an internal synchronous RAM with a programmable wait-state count.
- Signals completion with a one-cycle mem_ready pulse, which the CPU controller waits on.
- Hosts the memory-mapped LED register that drives the board LED.

Parameters:
DEPTH_WORDS, 256, RAM size in 32-bit words (power of two, 16..4096)
WAIT_CYCLES, 2, extra busy cycles per access (0..15)
LED_ADDR, 32'h0000_FFFC, byte address of the LED register

Ports:
clk  input  1  system clock, rising edge
reset  input  1  reset; asynchronous, active-low
MemRead  input  1  read request, level, held until mem_ready
MemWrite  input  1  write request, level, held until mem_ready
address_data  input  32  byte address from CPU
data_in  input  32  write data from CPU
data_out  output  32  registered read data to CPU
mem_ready  output  1  one-cycle completion pulse
misaligned_err  output  1  one-cycle pulse, coincident with mem_ready, on a rejected access
led  output  1  LED register bit 0

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - FSM to IDLE, wait counter to 0;
  - data_out=0, mem_ready=0, misaligned_err=0, led=0.
  - RAM contents are not cleared.
  - Reset mid-access aborts the access; a write not yet committed is lost.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - At a rising edge with MemRead|MemWrite=1, latch address, data_in and op (write has priority if both are high; the read is dropped).
  - Load the counter with WAIT_CYCLES. Go to BUSY, or directly to RESP if WAIT_CYCLES=0.
- BUSY:
  - Decrement the counter each cycle. When the counter reaches 1, go to RESP on the next edge.
  - Changes on the request inputs are ignored; the latched copies are used.
- Transition into RESP (single edge):
  - Aligned RAM write: RAM[addr[log2(DEPTH_WORDS)+1:2]] <= wdata.
  - LED write: led <= wdata[0].
  - Aligned RAM read: data_out <= RAM word.
  - LED read: data_out <= {31'b0, led}.
  - Out-of-range read (address >= 4*DEPTH_WORDS and not LED_ADDR): data_out <= 0. Out-of-range write is discarded.
  - Misaligned (addr[1:0] != 0): no RAM or LED change, data_out unchanged, misaligned_err=1 during RESP.
- RESP:
  - mem_ready=1 for exactly this cycle.
  - Next state is always IDLE.
  - data_out holds until the next read completes; writes never change data_out.
- Latency: mem_ready is high in the cycle beginning WAIT_CYCLES+1 edges after the accept edge.
  - WAIT_CYCLES=2 gives 3 edges. WAIT_CYCLES=0 gives 1 edge.
- Back-to-back: a request still high in IDLE after RESP is accepted as a new access. Minimum spacing is WAIT_CYCLES+2 cycles accept-to-accept.
- Read-after-write to the same address returns the new data (the write commits before the later read's access edge).
- Counter width is 4 bits; WAIT_CYCLES above 15 is illegal and must be caught by a synthesis-time check.

Test Plan:
- Reset then idle: reset=0 for 2 cycles, release -> data_out=0, mem_ready=0, led=0; no mem_ready with no request.
- Write/read, WAIT_CYCLES=2: write 32'hDEADBEEF to 0x40, then read 0x40 -> each mem_ready exactly 3 edges after accept; data_out=32'hDEADBEEF.
- LED and range: write 1 to LED_ADDR -> led=1, read LED_ADDR returns 32'h1. Read 0x2000 -> data_out=0. Write 5 to 0x2000 then read 0x0 -> RAM[0] unchanged.
- Misaligned: write to 0x42 -> misaligned_err and mem_ready high in the same cycle; RAM[0x40>>2] unchanged; data_out unchanged.
- Simultaneous and held requests: MemRead=MemWrite=1 at 0x10 with data 7 -> write performed, then read 0x10 returns 7. Holding MemRead for 10 cycles with WAIT_CYCLES=0 -> mem_ready every 2nd cycle.
- Reset mid-access: assert reset in BUSY during a write of 9 to 0x8 -> no mem_ready, RAM[2] retains its old value, FSM is IDLE on release.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Data-memory controller for the multicycle CPU data port: word RAM with a
// programmable wait-state count, one-cycle mem_ready pulse and a memory-mapped LED bit.
//
// state | meaning
// IDLE  | waiting for MemRead/MemWrite
// BUSY  | counting wait states on the latched request
// RESP  | mem_ready (plus misaligned_err on a rejected access) for one cycle
module data_mem_ctrl #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] LED_ADDR    = 32'h0000_FFFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] address_data,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        mem_ready,
  output logic        misaligned_err,
  output logic        led
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  generate
    if (WAIT_CYCLES > 15) begin : g_bad_wait
      $error("data_mem_ctrl: WAIT_CYCLES must be in 0..15");
    end
    if ((DEPTH_WORDS < 16) || (DEPTH_WORDS > 4096) ||
        ((DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0)) begin : g_bad_depth
      $error("data_mem_ctrl: DEPTH_WORDS must be a power of two in 16..4096");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    r_cnt;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic          r_is_wr;
  logic          r_mis_err;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic          w_req;
  logic          w_commit;
  logic [31:0]   w_addr;
  logic [31:0]   w_wdata;
  logic          w_is_wr;
  logic          w_misaligned;
  logic          w_is_led;
  logic          w_in_range;
  logic          w_ram_we;
  logic [AW-1:0] w_idx;

  assign w_req = MemRead | MemWrite;

  // With zero wait states the access commits on the accept edge itself, so the
  // live inputs are used in IDLE; otherwise the latched copies are used.
  assign w_addr  = (r_state == S_IDLE) ? address_data : r_addr;
  assign w_wdata = (r_state == S_IDLE) ? data_in      : r_wdata;
  assign w_is_wr = (r_state == S_IDLE) ? MemWrite     : r_is_wr;

  assign w_commit = ((r_state == S_IDLE) && w_req && (WAIT_CYCLES == 0)) ||
                    ((r_state == S_BUSY) && (r_cnt == 4'd1));

  assign w_misaligned = (w_addr[1:0] != 2'b00);
  assign w_is_led     = (w_addr == LED_ADDR);
  assign w_in_range   = (w_addr[31:AW+2] == '0);
  assign w_idx        = w_addr[AW+1:2];

  assign w_ram_we = w_commit && reset && w_is_wr && !w_misaligned &&
                    !w_is_led && w_in_range;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_state_nxt = (WAIT_CYCLES == 0) ? S_RESP : S_BUSY;
        end
      end
      S_BUSY: begin
        if (r_cnt == 4'd1) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // RAM contents survive reset; the write is gated so reset aborts it.
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      r_mem[w_idx] <= w_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_addr    <= 32'd0;
      r_wdata   <= 32'd0;
      r_is_wr   <= 1'b0;
      r_mis_err <= 1'b0;
      data_out  <= 32'd0;
      led       <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_mis_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_addr  <= address_data;
            r_wdata <= data_in;
            r_is_wr <= MemWrite;
            r_cnt   <= 4'(WAIT_CYCLES);
          end
        end
        S_BUSY:  r_cnt <= r_cnt - 4'd1;
        default: r_cnt <= r_cnt;
      endcase
      if (w_commit) begin
        if (w_misaligned) begin
          r_mis_err <= 1'b1;
        end else if (w_is_wr) begin
          if (w_is_led) begin
            led <= w_wdata[0];
          end
        end else if (w_is_led) begin
          data_out <= {31'b0, led};
        end else if (w_in_range) begin
          data_out <= r_mem[w_idx];
        end else begin
          data_out <= 32'd0;
        end
      end
    end
  end

  assign mem_ready      = (r_state == S_RESP);
  assign misaligned_err = r_mis_err;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: directed and random accesses against a word-level
// memory/LED model, plus a zero-wait-state instance for back-to-back timing.
module tb_data_mem_ctrl;

  localparam int          DEPTH = 256;
  localparam logic [31:0] LED   = 32'h0000_FFFC;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  always #5 clk = ~clk;

  logic        rd, wr, rdy, mis, led;
  logic [31:0] addr, wd, dout;
  logic        rd0, wr0, rdy0, mis0, led0;
  logic [31:0] addr0, wd0, dout0;

  data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2), .LED_ADDR(LED)) dut (
    .clk(clk), .reset(reset), .MemRead(rd), .MemWrite(wr),
    .address_data(addr), .data_in(wd), .data_out(dout),
    .mem_ready(rdy), .misaligned_err(mis), .led(led));

  data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0), .LED_ADDR(LED)) dut0 (
    .clk(clk), .reset(reset), .MemRead(rd0), .MemWrite(wr0),
    .address_data(addr0), .data_in(wd0), .data_out(dout0),
    .mem_ready(rdy0), .misaligned_err(mis0), .led(led0));

  int n_total = 0;
  int n_pass  = 0;

  logic [31:0] m_mem [DEPTH];
  logic        m_led;
  logic [31:0] m_dout;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Word-level view of the address map: misaligned rejected, LED, RAM, else void.
  task automatic model(input logic w, input logic [31:0] a, input logic [31:0] d,
                       output logic e_mis);
    e_mis = 1'b0;
    if (a[1:0] != 2'b00) begin
      e_mis = 1'b1;
    end else if (w) begin
      if (a == LED) m_led = d[0];
      else if (a < 32'(4 * DEPTH)) m_mem[a[9:2]] = d;
    end else begin
      if (a == LED) m_dout = {31'b0, m_led};
      else if (a < 32'(4 * DEPTH)) m_dout = m_mem[a[9:2]];
      else m_dout = 32'd0;
    end
  endtask

  task automatic access(input string tag, input logic w, input logic r,
                        input logic [31:0] a, input logic [31:0] d);
    int   n;
    logic e_mis;
    @(negedge clk);
    wr = w; rd = r; addr = a; wd = d;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (!rdy) begin
        addr = $urandom;
        wd   = $urandom;
      end
    end while (!rdy && n < 20);
    wr = 1'b0; rd = 1'b0;
    model(w, a, d, e_mis);
    chk({tag, " latency"}, 32'(n), 32'd3);
    chk({tag, " mis"},  32'(mis), 32'(e_mis));
    chk({tag, " dout"}, dout, m_dout);
    chk({tag, " led"},  32'(led), 32'(m_led));
    @(posedge clk); #1;
    chk({tag, " ready pulse"}, 32'(rdy), 32'd0);
  endtask

  initial begin
    int          cnt;
    int          adj;
    logic        prev;
    int          sel;
    int          op;
    logic [31:0] a;

    rd = 0; wr = 0; addr = 0; wd = 0;
    rd0 = 0; wr0 = 0; addr0 = 0; wd0 = 0;
    m_led = 0; m_dout = 0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("reset dout", dout, 32'd0);
    chk("reset rdy",  32'(rdy), 32'd0);
    chk("reset led",  32'(led), 32'd0);
    chk("reset mis",  32'(mis), 32'd0);
    cnt = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (rdy) cnt++;
    end
    chk("idle no ready", 32'(cnt), 32'd0);

    for (int i = 0; i < DEPTH; i++) access("init", 1'b1, 1'b0, 32'(i) << 2, $urandom);

    access("wr40", 1'b1, 1'b0, 32'h40, 32'hDEADBEEF);
    access("rd40", 1'b0, 1'b1, 32'h40, 32'h0);
    chk("rd40 value", dout, 32'hDEADBEEF);
    access("led wr", 1'b1, 1'b0, LED, 32'h1);
    chk("led on", 32'(led), 32'd1);
    access("led rd", 1'b0, 1'b1, LED, 32'h0);
    chk("led rd value", dout, 32'h1);
    access("oor rd", 1'b0, 1'b1, 32'h2000, 32'h0);
    chk("oor rd value", dout, 32'h0);
    access("oor wr", 1'b1, 1'b0, 32'h2000, 32'h5);
    access("rd0", 1'b0, 1'b1, 32'h0, 32'h0);
    access("mis wr", 1'b1, 1'b0, 32'h42, 32'h1234_5678);
    access("rd40b", 1'b0, 1'b1, 32'h40, 32'h0);
    chk("rd40 after mis", dout, 32'hDEADBEEF);
    access("both", 1'b1, 1'b1, 32'h10, 32'h7);
    access("rd10", 1'b0, 1'b1, 32'h10, 32'h0);
    chk("rd10 value", dout, 32'h7);

    repeat (200) begin
      sel = $urandom_range(0, 9);
      if (sel < 6)       a = 32'($urandom_range(0, DEPTH - 1)) << 2;
      else if (sel == 6) a = LED;
      else if (sel == 7) a = 32'h400 + (32'($urandom_range(0, 1000)) << 2);
      else               a = (32'($urandom_range(0, DEPTH - 1)) << 2) + 32'($urandom_range(1, 3));
      op = $urandom_range(0, 2);
      access("rand", op != 0, op != 1, a, $urandom);
    end

    // reset during BUSY of a write of 9 to 0x8
    @(negedge clk);
    wr = 1'b1; addr = 32'h8; wd = 32'h9;
    @(posedge clk); #1;
    reset = 1'b0; wr = 1'b0;
    m_led = 1'b0; m_dout = 32'd0;
    cnt = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (rdy) cnt++;
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (rdy) cnt++;
    end
    chk("abort no ready", 32'(cnt), 32'd0);
    chk("abort dout", dout, 32'd0);
    chk("abort led", 32'(led), 32'd0);
    access("rd8", 1'b0, 1'b1, 32'h8, 32'h0);

    // zero wait states: held read completes every second cycle
    @(negedge clk);
    rd0 = 1'b1; addr0 = LED;
    cnt = 0; adj = 0; prev = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (rdy0) cnt++;
      if (rdy0 && prev) adj++;
      prev = rdy0;
    end
    rd0 = 1'b0;
    chk("w0 held pulses", 32'(cnt), 32'd5);
    chk("w0 adjacent", 32'(adj), 32'd0);
    chk("w0 led rd", dout0, 32'd0);
    @(negedge clk);
    wr0 = 1'b1; addr0 = 32'h10; wd0 = 32'hA5A5_0F0F;
    @(posedge clk); #1;
    chk("w0 wr latency", 32'(rdy0), 32'd1);
    wr0 = 1'b0;
    @(posedge clk); #1;
    chk("w0 ready drop", 32'(rdy0), 32'd0);
    @(negedge clk);
    rd0 = 1'b1; addr0 = 32'h10;
    @(posedge clk); #1;
    chk("w0 rd latency", 32'(rdy0), 32'd1);
    chk("w0 rd value", dout0, 32'hA5A5_0F0F);
    rd0 = 1'b0;
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
